// File: rtl/axis_fifo_wr_arbiter.sv
// Two-port AXI-Stream to FIFO write arbiter.
// Round-robin between two slave ports, with the grant locked for a whole packet.
// Beats are forwarded combinationally to the FIFO write port. Per-port packet counters wrap at 16 bits.
module axis_fifo_wr_arbiter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_last,
    output logic [1:0]        grant,
    output logic [15:0]       pkt_cnt0,
    output logic [15:0]       pkt_cnt1
);

    // The state encoding is the one-hot grant, so grant is read straight from the register.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGnt0 = 2'b01,
        StGnt1 = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic        last_srv_q, last_srv_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;
    logic        xfer0, xfer1;

    // Ready depends only on the state and fifo_full, never on tvalid.
    always_comb begin
        s0_axis_tready = (state_q == StGnt0) && !fifo_full;
        s1_axis_tready = (state_q == StGnt1) && !fifo_full;
        xfer0          = s0_axis_tvalid && s0_axis_tready;
        xfer1          = s1_axis_tvalid && s1_axis_tready;
    end

    // Next state: arbitrate in idle, then hold the grant until the granted port's tlast beat.
    always_comb begin
        state_d    = state_q;
        last_srv_d = last_srv_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        unique case (state_q)
            StIdle: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    // Contention goes to the port that did not finish the previous packet.
                    state_d = last_srv_q ? StGnt0 : StGnt1;
                end else if (s0_axis_tvalid) begin
                    state_d = StGnt0;
                end else if (s1_axis_tvalid) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (xfer0 && s0_axis_tlast) begin
                    state_d    = StIdle;
                    last_srv_d = 1'b0;
                    cnt0_d     = cnt0_q + 16'd1;
                end
            end
            StGnt1: begin
                if (xfer1 && s1_axis_tlast) begin
                    state_d    = StIdle;
                    last_srv_d = 1'b1;
                    cnt1_d     = cnt1_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Mux the granted port onto the FIFO write interface; everything is zero while idle.
    always_comb begin
        fifo_wr_en = xfer0 || xfer1;
        fifo_data  = '0;
        fifo_last  = 1'b0;
        unique case (state_q)
            StGnt0: begin
                fifo_data = s0_axis_tdata;
                fifo_last = s0_axis_tlast;
            end
            StGnt1: begin
                fifo_data = s1_axis_tdata;
                fifo_last = s1_axis_tlast;
            end
            default: begin
                fifo_data = '0;
                fifo_last = 1'b0;
            end
        endcase
    end

    // State and counter registers. last_srv resets to 1 so that port 0 wins the first contention.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            last_srv_q <= 1'b1;
            cnt0_q     <= 16'd0;
            cnt1_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            last_srv_q <= last_srv_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign grant    = state_q;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
// Directed bench for axis_fifo_wr_arbiter.
// Each port has a queue-driven source, and FIFO writes are captured into a queue.
module tb_axis_fifo_wr_arbiter;

    localparam int DATA_W = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [DATA_W-1:0] s0_axis_tdata, s1_axis_tdata;
    logic              s0_axis_tvalid, s1_axis_tvalid;
    logic              s0_axis_tlast, s1_axis_tlast;
    logic              s0_axis_tready, s1_axis_tready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_last;
    logic [1:0]        grant;
    logic [15:0]       pkt_cnt0, pkt_cnt1;

    // Entries are {tlast, tdata}.
    logic [DATA_W:0] q0[$];
    logic [DATA_W:0] q1[$];
    logic [DATA_W:0] got[$];
    bit              en0, en1, full_ctl;
    int              n_cmp, n_err;

    axis_fifo_wr_arbiter #(.DATA_W(DATA_W)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .fifo_full      (fifo_full),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_data      (fifo_data),
        .fifo_last      (fifo_last),
        .grant          (grant),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1)
    );

    initial forever #5 aclk = ~aclk;

    // Sources: note each handshake at the negedge, pop it after the next posedge, then drive the new head.
    initial begin
        bit x0, x1;
        s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
        s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
        fifo_full = 1'b0;
        forever begin
            @(negedge aclk);
            x0 = s0_axis_tvalid && s0_axis_tready;
            x1 = s1_axis_tvalid && s1_axis_tready;
            @(posedge aclk);
            #1;
            if (x0 && q0.size() > 0) void'(q0.pop_front());
            if (x1 && q1.size() > 0) void'(q1.pop_front());
            fifo_full      = full_ctl;
            s0_axis_tvalid = en0 && (q0.size() > 0);
            s1_axis_tvalid = en1 && (q1.size() > 0);
            if (q0.size() > 0) {s0_axis_tlast, s0_axis_tdata} = q0[0];
            else               {s0_axis_tlast, s0_axis_tdata} = '0;
            if (q1.size() > 0) {s1_axis_tlast, s1_axis_tdata} = q1[0];
            else               {s1_axis_tlast, s1_axis_tdata} = '0;
        end
    end

    // Capture FIFO writes.
    always @(negedge aclk) begin
        if (aresetn && fifo_wr_en) got.push_back({fifo_last, fifo_data});
    end

    task automatic cyc();
        @(negedge aclk);
        #1;
    endtask

    task automatic push_pkt(input int port, input logic [DATA_W-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [DATA_W:0] e;
            e = {(i == len - 1), base + DATA_W'(i)};
            if (port == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (grant !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b expected 00", grant); end
        n_cmp++;
        if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin
            n_err++; $display("FAIL rst_tready: got %b expected 00", {s0_axis_tready, s1_axis_tready});
        end
        n_cmp++;
        if ({fifo_wr_en, fifo_last, fifo_data} !== '0) begin
            n_err++; $display("FAIL rst_fifo: got %b/%b/%h expected 0/0/00", fifo_wr_en, fifo_last, fifo_data);
        end
        n_cmp++;
        if ({pkt_cnt0, pkt_cnt1} !== 32'd0) begin
            n_err++; $display("FAIL rst_cnt: got %h/%h expected 0000/0000", pkt_cnt0, pkt_cnt1);
        end
        cyc();
        aresetn = 1'b1;
        cyc();
        n_cmp++;
        if (grant !== 2'b00) begin n_err++; $display("FAIL idle_grant: got %b expected 00", grant); end
    endtask

    task automatic test_first_contention();
        logic [9:0]      exp_wr = 10'b0011101110;
        logic [1:0]      exp_gr[10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00,
                                        2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [DATA_W:0] exp_b[6] = '{{1'b0, 8'hA1}, {1'b0, 8'hA2}, {1'b1, 8'hA3},
                                      {1'b0, 8'hB1}, {1'b0, 8'hB2}, {1'b1, 8'hB3}};
        logic [DATA_W:0] obs;
        got.delete();
        push_pkt(0, 8'hA1, 3);
        push_pkt(1, 8'hB1, 3);
        en0 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_cmp++;
            if (fifo_wr_en !== exp_wr[i]) begin
                n_err++; $display("FAIL fc_wr[%0d]: got %b expected %b", i, fifo_wr_en, exp_wr[i]);
            end
            n_cmp++;
            if (grant !== exp_gr[i]) begin
                n_err++; $display("FAIL fc_grant[%0d]: got %b expected %b", i, grant, exp_gr[i]);
            end
        end
        n_cmp++;
        if (got.size() != 6) begin n_err++; $display("FAIL fc_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6; i++) begin
            obs = (i < got.size()) ? got[i] : 'x;
            n_cmp++;
            if (obs !== exp_b[i]) begin
                n_err++; $display("FAIL fc_beat[%0d]: got %h expected %h", i, obs, exp_b[i]);
            end
        end
        n_cmp++;
        if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
            n_err++; $display("FAIL fc_cnt: got %0d/%0d expected 1/1", pkt_cnt0, pkt_cnt1);
        end
        en0 = 1'b0; en1 = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0]      order[$];
        logic [1:0]      prev = 2'b00;
        logic [1:0]      exp_o[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [DATA_W:0] exp_b[8] = '{{1'b0, 8'h10}, {1'b1, 8'h11}, {1'b0, 8'h30}, {1'b1, 8'h31},
                                      {1'b0, 8'h20}, {1'b1, 8'h21}, {1'b0, 8'h40}, {1'b1, 8'h41}};
        logic [1:0]      og;
        logic [DATA_W:0] obs;
        got.delete();
        push_pkt(0, 8'h10, 2); push_pkt(0, 8'h20, 2);
        push_pkt(1, 8'h30, 2); push_pkt(1, 8'h40, 2);
        en0 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (grant != 2'b00 && prev == 2'b00) order.push_back(grant);
            prev = grant;
        end
        n_cmp++;
        if (order.size() != 4) begin n_err++; $display("FAIL rr_grants: got %0d expected 4", order.size()); end
        for (int i = 0; i < 4; i++) begin
            og = (i < order.size()) ? order[i] : 2'bxx;
            n_cmp++;
            if (og !== exp_o[i]) begin
                n_err++; $display("FAIL rr_order[%0d]: got %b expected %b", i, og, exp_o[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            obs = (i < got.size()) ? got[i] : 'x;
            n_cmp++;
            if (obs !== exp_b[i]) begin
                n_err++; $display("FAIL rr_beat[%0d]: got %h expected %h", i, obs, exp_b[i]);
            end
        end
        n_cmp++;
        if (pkt_cnt0 !== 16'd3 || pkt_cnt1 !== 16'd3) begin
            n_err++; $display("FAIL rr_cnt: got %0d/%0d expected 3/3", pkt_cnt0, pkt_cnt1);
        end
        en0 = 1'b0; en1 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [11:0]     exp_wr = 12'b001100000110;
        logic [DATA_W:0] obs;
        got.delete();
        push_pkt(0, 8'hC1, 4);
        en0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_cmp++;
            if (fifo_wr_en !== exp_wr[i]) begin
                n_err++; $display("FAIL bp_wr[%0d]: got %b expected %b", i, fifo_wr_en, exp_wr[i]);
            end
            if (i >= 3 && i <= 7) begin
                n_cmp++;
                if (s0_axis_tready !== 1'b0 || grant !== 2'b01) begin
                    n_err++;
                    $display("FAIL bp_hold[%0d]: got tready %b grant %b expected 0/01", i, s0_axis_tready, grant);
                end
            end
            if (i == 2) full_ctl = 1'b1;
            if (i == 7) full_ctl = 1'b0;
        end
        n_cmp++;
        if (got.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            obs = (i < got.size()) ? got[i] : 'x;
            n_cmp++;
            if (obs !== {(i == 3), 8'hC1 + 8'(i)}) begin
                n_err++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, obs, {(i == 3), 8'hC1 + 8'(i)});
            end
        end
        n_cmp++;
        if (pkt_cnt0 !== 16'd4) begin n_err++; $display("FAIL bp_cnt: got %0d expected 4", pkt_cnt0); end
        en0 = 1'b0;
    endtask

    task automatic test_packet_lock();
        logic [10:0]     pat = 11'b11111001011;
        logic [DATA_W:0] exp_b[5] = '{{1'b0, 8'hD1}, {1'b0, 8'hD2}, {1'b0, 8'hD3}, {1'b1, 8'hD4},
                                      {1'b1, 8'hE1}};
        logic [DATA_W:0] obs;
        got.delete();
        push_pkt(0, 8'hD1, 4);
        push_pkt(1, 8'hE1, 1);
        en0 = 1'b1; en1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i >= 1 && i <= 7) begin
                n_cmp++;
                if (s1_axis_tready !== 1'b0 || grant !== 2'b01) begin
                    n_err++;
                    $display("FAIL lock[%0d]: got s1_tready %b grant %b expected 0/01", i, s1_axis_tready, grant);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if (grant !== 2'b00) begin n_err++; $display("FAIL lock_idle: got %b expected 00", grant); end
            end
            if (i == 9) begin
                n_cmp++;
                if (s1_axis_tready !== 1'b1 || grant !== 2'b10) begin
                    n_err++;
                    $display("FAIL lock_gnt1: got s1_tready %b grant %b expected 1/10", s1_axis_tready, grant);
                end
            end
            en0 = pat[i+1];
            en1 = 1'b1;
        end
        cyc();
        for (int i = 0; i < 5; i++) begin
            obs = (i < got.size()) ? got[i] : 'x;
            n_cmp++;
            if (obs !== exp_b[i]) begin
                n_err++; $display("FAIL lock_beat[%0d]: got %h expected %h", i, obs, exp_b[i]);
            end
        end
        n_cmp++;
        if (pkt_cnt0 !== 16'd5 || pkt_cnt1 !== 16'd4) begin
            n_err++; $display("FAIL lock_cnt: got %0d/%0d expected 5/4", pkt_cnt0, pkt_cnt1);
        end
        en0 = 1'b0; en1 = 1'b0;
    endtask

    task automatic test_counter_wrap();
        int n;
        cyc();
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0) begin
            n_err++; $display("FAIL wrap_rst: got %h/%h expected 0000/0000", pkt_cnt0, pkt_cnt1);
        end
        cyc();
        aresetn = 1'b1;
        for (int k = 0; k < 65535; k++) q1.push_back({1'b1, 8'(k)});
        en1 = 1'b1;
        n = 0;
        while (pkt_cnt1 !== 16'hFFFF && n < 140000) begin
            cyc();
            n++;
        end
        n_cmp++;
        if (pkt_cnt1 !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_preload: got %h expected ffff", pkt_cnt1);
        end
        got.delete();
        q1.push_back({1'b1, 8'h5A});
        repeat (4) cyc();
        n_cmp++;
        if (pkt_cnt1 !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h expected 0000", pkt_cnt1); end
        n_cmp++;
        if (pkt_cnt0 !== 16'h0000) begin n_err++; $display("FAIL wrap_cnt0: got %h expected 0000", pkt_cnt0); end
        n_cmp++;
        if (got.size() != 1 || got[0] !== {1'b1, 8'h5A}) begin
            n_err++; $display("FAIL wrap_beat: got %0d beats expected 1 beat 15a", got.size());
        end
        en1 = 1'b0;
        got.delete();
    endtask

    task automatic test_reset_mid_packet();
        logic [DATA_W:0] obs;
        // Finish a port-0 packet first so that, without reset, port 1 would win the next contention.
        push_pkt(0, 8'h70, 1);
        en0 = 1'b1;
        repeat (4) cyc();
        en0 = 1'b0;
        got.delete();
        push_pkt(1, 8'hF1, 4);
        en1 = 1'b1;
        repeat (3) cyc();
        n_cmp++;
        if (grant !== 2'b10 || fifo_wr_en !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: got grant %b wr %b expected 10/1", grant, fifo_wr_en);
        end
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (grant !== 2'b00) begin n_err++; $display("FAIL mid_grant: got %b expected 00", grant); end
        n_cmp++;
        if ({s0_axis_tready, s1_axis_tready, fifo_wr_en} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_ready: got %b expected 000", {s0_axis_tready, s1_axis_tready, fifo_wr_en});
        end
        n_cmp++;
        if ({fifo_last, fifo_data} !== '0) begin
            n_err++; $display("FAIL mid_data: got %h expected 000", {fifo_last, fifo_data});
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            obs = (i < got.size()) ? got[i] : 'x;
            n_cmp++;
            if (obs !== {1'b0, 8'hF1 + 8'(i)}) begin
                n_err++; $display("FAIL mid_beat[%0d]: got %h expected %h", i, obs, {1'b0, 8'hF1 + 8'(i)});
            end
        end
        n_cmp++;
        if (got.size() != 2) begin n_err++; $display("FAIL mid_count: got %0d expected 2", got.size()); end
        q0.delete(); q1.delete(); got.delete();
        push_pkt(0, 8'h61, 1);
        push_pkt(1, 8'h62, 1);
        en0 = 1'b1; en1 = 1'b1;
        repeat (2) cyc();
        aresetn = 1'b1;
        cyc();
        n_cmp++;
        if (grant !== 2'b01 || s1_axis_tready !== 1'b0) begin
            n_err++; $display("FAIL mid_first: got grant %b s1_tready %b expected 01/0", grant, s1_axis_tready);
        end
        repeat (4) cyc();
        n_cmp++;
        if (got.size() != 2 || got[0] !== {1'b1, 8'h61} || got[1] !== {1'b1, 8'h62}) begin
            n_err++; $display("FAIL mid_after: got %0d beats expected 161,162", got.size());
        end
        n_cmp++;
        if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
            n_err++; $display("FAIL mid_cnt: got %0d/%0d expected 1/1", pkt_cnt0, pkt_cnt1);
        end
        en0 = 1'b0; en1 = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        en0      = 1'b0;
        en1      = 1'b0;
        full_ctl = 1'b0;
        aresetn  = 1'b0;
        test_reset();
        test_first_contention();
        test_round_robin();
        test_backpressure();
        test_packet_lock();
        test_counter_wrap();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
